// File: rtl/shift_univ_seq.sv
// +--------------------------------------------------------------------------+
// | shift_univ_seq : universal shift register with an auto-shift sequencer   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module shift_univ_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       s,
  input  logic             srsi,
  input  logic             slsi,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] dout,
  output logic             sro,
  output logic             slo,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_rem;
  logic [WIDTH-1:0] r_dout;
  logic             r_busy;
  logic             r_done;
  logic             w_run_op;

  function automatic logic [WIDTH-1:0] f_apply(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] ld,
    input logic             si_r,
    input logic             si_l
  );
    logic [WIDTH-1:0] r;
    r = d;
    case (op)
      3'b001:  r = {si_r, d[WIDTH-1:1]};
      3'b010:  r = {d[WIDTH-2:0], si_l};
      3'b011:  r = ld;
      3'b100:  r = {d[0], d[WIDTH-1:1]};
      3'b101:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      3'b110:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      3'b111:  r = '0;
      default: r = d;
    endcase
    return r;
  endfunction

  // Only genuine shift/rotate ops are worth sequencing; hold, load and clear
  // would just repeat the same result.
  assign w_run_op = (s == 3'b001) || (s == 3'b010) || (s == 3'b100) ||
                    (s == 3'b101) || (s == 3'b110);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_op    <= 3'b000;
      r_rem   <= c_ZERO;
      r_dout  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op  <= s;
            r_rem <= cnt;
            if (w_run_op && (cnt != c_ZERO)) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else if (en) begin
            r_dout <= f_apply(s, r_dout, din, srsi, slsi);
          end
        end
        ST_RUN: begin
          r_dout <= f_apply(r_op, r_dout, din, srsi, slsi);
          r_rem  <= r_rem - c_ONE;
          if (r_rem == c_ONE) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign sro  = r_dout[0];
  assign slo  = r_dout[WIDTH-1];
  assign busy = r_busy;
  assign done = r_done;

endmodule

`default_nettype wire
